// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front-end: opcode map, instruction
// field positions and reservation-station classes. The decoder imports
// this package too, so field positions live here and nowhere else.
package tomasulo_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 2;
    localparam int RD_LSB  = 3;
    localparam int RD_MSB  = 5;
    localparam int RS_LSB  = 6;
    localparam int RS_MSB  = 8;
    localparam int OFF_LSB = 9;
    localparam int OFF_MSB = 15;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_AS   = 2'd1;
    localparam logic [1:0] CLS_LS   = 2'd2;

    // Which reservation station an opcode needs a free slot in.
    // HALT never reaches the queue, so it is grouped with NOP.
    function automatic logic [1:0] op_class(input logic [2:0] op);
        logic [1:0] cls;
        case (op)
            OP_LD, OP_ST:                   cls = CLS_LS;
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: cls = CLS_AS;
            default:                        cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding fetched instructions. Occupancy is kept
// as an explicit count so full/empty never depend on pointer comparison.
// The caller guarantees no push when full and no pop when empty.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 16
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         push,
    input  logic                         pop,
    input  logic [IW-1:0]                din,
    output logic [IW-1:0]                head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_queue.sv
// Fetch/issue front-end. Walks the PC through the instruction ROM,
// buffers words in instr_fifo, and releases the head to the decoder only
// when the station it targets has room. Fetching stops for good on HALT.
module instr_queue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 8,
    parameter int IW    = 16
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         fetch_en,
    output logic [PCW-1:0]               imem_addr,
    input  logic [IW-1:0]                imem_data,
    input  logic                         ASFull,
    input  logic                         LSFull,
    output logic [IW-1:0]                instr_out,
    output logic                         issue_valid,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         halted,
    output logic                         done
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PCW-1:0] pc;
    logic [IW-1:0]  head;
    logic [CW-1:0]  count;
    logic           fetch_ok;
    logic           fetch_is_halt;
    logic           push;
    logic           pop;
    logic           station_free;

    instr_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (push),
        .pop   (pop),
        .din   (imem_data),
        .head  (head),
        .count (count)
    );

    // Fetch and issue decisions, all taken from the current registered state.
    always_comb begin
        fetch_ok      = fetch_en && !halted && (count < FULL_COUNT);
        fetch_is_halt = (imem_data[OPC_MSB:OPC_LSB] == OP_HALT);
        push          = fetch_ok && !fetch_is_halt;
        case (op_class(head[OPC_MSB:OPC_LSB]))
            CLS_AS:  station_free = !ASFull;
            CLS_LS:  station_free = !LSFull;
            default: station_free = 1'b1;
        endcase
        pop = (count != '0) && station_free;
    end

    // PC, halt flag and the registered issue port toward the decoder.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc          <= '0;
            halted      <= 1'b0;
            instr_out   <= '0;
            issue_valid <= 1'b0;
        end else begin
            if (fetch_ok) begin
                if (fetch_is_halt) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + PCW'(1);
                end
            end
            if (pop) begin
                instr_out   <= head;
                issue_valid <= 1'b1;
            end else begin
                instr_out   <= '0;
                issue_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign q_count   = count;
    assign done      = halted && (count == '0) && !issue_valid;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: a reset/HALT vector table, directed sequences for
// backpressure, in-order blocking, streaming, wrap and async reset, and a
// randomized run checked against a queue-based reference model.
module tb_instr_queue;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        fetch_en = 1'b0;
    logic        fetch_en_w = 1'b0;
    logic        as_full = 1'b0;
    logic        ls_full = 1'b0;

    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic        issue_valid;
    logic [2:0]  q_count;
    logic        halted;
    logic        done;

    logic [2:0]  imem_addr_w;
    logic [15:0] imem_data_w;
    logic [15:0] instr_out_w;
    logic        issue_valid_w;
    logic [2:0]  q_count_w;
    logic        halted_w;
    logic        done_w;

    logic [15:0] rom   [256];
    logic [15:0] rom_w [8];

    int tests  = 0;
    int failed = 0;

    // reference model state
    logic [7:0]  m_pc;
    logic        m_halted;
    logic [15:0] mq [$];
    logic [15:0] m_instr;
    logic        m_valid;

    assign imem_data   = rom[imem_addr];
    assign imem_data_w = rom_w[imem_addr_w];

    always #5 CLK = ~CLK;

    instr_queue #(.DEPTH(4), .PCW(8), .IW(16)) dut (
        .CLK (CLK), .CLR (CLR), .fetch_en (fetch_en),
        .imem_addr (imem_addr), .imem_data (imem_data),
        .ASFull (as_full), .LSFull (ls_full),
        .instr_out (instr_out), .issue_valid (issue_valid),
        .q_count (q_count), .halted (halted), .done (done)
    );

    instr_queue #(.DEPTH(4), .PCW(3), .IW(16)) dut_w (
        .CLK (CLK), .CLR (CLR), .fetch_en (fetch_en_w),
        .imem_addr (imem_addr_w), .imem_data (imem_data_w),
        .ASFull (as_full), .LSFull (ls_full),
        .instr_out (instr_out_w), .issue_valid (issue_valid_w),
        .q_count (q_count_w), .halted (halted_w), .done (done_w)
    );

    typedef struct {
        logic        fetch_en;
        logic        as_full;
        logic        ls_full;
        logic [15:0] instr;
        logic        valid;
        logic [2:0]  count;
        logic        halted;
        logic        done;
        logic [7:0]  pc;
    } vec_t;

    vec_t vecs [5];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Station availability for an opcode, straight from the opcode map.
    function automatic bit station_ready(input logic [2:0] op, input logic as, input logic ls);
        if (op == 3'd1 || op == 3'd2) return !ls;
        if (op >= 3'd3 && op <= 3'd6) return !as;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pc     = 8'd0;
        m_halted = 1'b0;
        mq.delete();
        m_instr  = 16'h0000;
        m_valid  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs now driven.
    task automatic model_update();
        bit          do_pop;
        bit          do_fetch;
        logic [15:0] word;
        logic [15:0] hd;
        do_pop = 1'b0;
        if (mq.size() > 0) begin
            hd = mq[0];
            do_pop = station_ready(hd[2:0], as_full, ls_full);
        end
        do_fetch = fetch_en && !m_halted && (mq.size() < 4);
        word = rom[m_pc];
        if (do_pop) begin
            m_instr = mq.pop_front();
            m_valid = 1'b1;
        end else begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end
        if (do_fetch) begin
            if (word[2:0] == 3'b111) begin
                m_halted = 1'b1;
            end else begin
                mq.push_back(word);
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic check_model();
        check_output("instr_out",   32'(instr_out),   32'(m_instr));
        check_output("issue_valid", 32'(issue_valid), 32'(m_valid));
        check_output("q_count",     32'(q_count),     32'(mq.size()));
        check_output("halted",      32'(halted),      32'(m_halted));
        check_output("done",        32'(done),        32'(m_halted && mq.size() == 0 && !m_valid));
        check_output("imem_addr",   32'(imem_addr),   32'(m_pc));
    endtask

    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic apply_stimulus(input logic fe, input logic as, input logic ls);
        fetch_en = fe;
        as_full  = as;
        ls_full  = ls;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        CLR = 1'b1;
        #1;
        model_reset();
        check_model();
        check_output("w_reset_pc",    32'(imem_addr_w),   32'd0);
        check_output("w_reset_count", 32'(q_count_w),     32'd0);
        check_output("w_reset_valid", 32'(issue_valid_w), 32'd0);
        #2;
        CLR = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int issues;
        for (int i = 0; i < 8; i++) rom_w[i] = 16'(((i + 1) & 127) << 9);
        fill_rom(16'h0007);
        model_reset();
        #12;

        // ---- table: one LD then HALT, stations free ----
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd1, 1'b0, 1'b0, 8'd1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0019, 1'b1, 3'd0, 1'b1, 1'b0, 8'd1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 8'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 8'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b1, 8'd1};
        rom[0] = 16'h0019;
        rom[1] = 16'h0007;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].fetch_en, vecs[i].as_full, vecs[i].ls_full);
            model_update();
            @(posedge CLK);
            #1;
            check_output("tbl_instr",  32'(instr_out),   32'(vecs[i].instr));
            check_output("tbl_valid",  32'(issue_valid), 32'(vecs[i].valid));
            check_output("tbl_count",  32'(q_count),     32'(vecs[i].count));
            check_output("tbl_halted", 32'(halted),      32'(vecs[i].halted));
            check_output("tbl_done",   32'(done),        32'(vecs[i].done));
            check_output("tbl_pc",     32'(imem_addr),   32'(vecs[i].pc));
        end

        // ---- backpressure until full, then release ----
        fill_rom(16'h0007);
        for (int i = 0; i < 6; i++) rom[i] = 16'(16'h0003 | (i << 9));
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("bp_no_issue", 32'(issue_valid), 32'd0);
        end
        check_output("bp_full_count", 32'(q_count),   32'd4);
        check_output("bp_pc_stalled", 32'(imem_addr), 32'd4);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("bp_instr", 32'(instr_out), 32'(16'h0003 | (i << 9)));
            if (issue_valid) issues++;
        end
        check_output("bp_issues", 32'(issues),    32'd6);
        check_output("bp_pc_end", 32'(imem_addr), 32'd6);
        step();
        check_output("bp_done", 32'(done), 32'd1);

        // ---- in-order blocking behind a stalled LD ----
        fill_rom(16'h0007);
        rom[0] = 16'h0001;
        rom[1] = 16'h0003;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("io_blocked", 32'(issue_valid), 32'd0);
        end
        check_output("io_count", 32'(q_count), 32'd2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step();
        check_output("io_first",  32'(instr_out),   32'h0001);
        check_output("io_first_v", 32'(issue_valid), 32'd1);
        step();
        check_output("io_second", 32'(instr_out),   32'h0003);
        check_output("io_second_v", 32'(issue_valid), 32'd1);

        // ---- steady stream: push and pop every cycle ----
        fill_rom(16'h0007);
        for (int i = 0; i < 30; i++) rom[i] = 16'(16'h0003 | (i << 3));
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step();
        check_output("st_first_valid", 32'(issue_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_output("st_count", 32'(q_count),     32'd1);
            check_output("st_valid", 32'(issue_valid), 32'd1);
            check_output("st_instr", 32'(instr_out),   32'(16'h0003 | (i << 3)));
        end

        // ---- PC and pointer wrap on the 3-bit PC instance ----
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        fetch_en_w = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_output("wr_pc",    32'(imem_addr_w),   32'(k % 8));
            check_output("wr_count", 32'(q_count_w),     32'd1);
            check_output("wr_valid", 32'(issue_valid_w), 32'(k >= 2));
            if (k >= 2) check_output("wr_instr", 32'(instr_out_w), 32'(rom_w[(k - 2) % 8]));
            check_output("wr_halted", 32'(halted_w), 32'd0);
        end
        fetch_en_w = 1'b0;

        // ---- asynchronous reset between edges ----
        fill_rom(16'h0007);
        for (int i = 0; i < 10; i++) rom[i] = 16'h0003;
        apply_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check_output("ar_pre_count", 32'(q_count),   32'd3);
        check_output("ar_pre_pc",    32'(imem_addr), 32'd3);
        #3;
        CLR = 1'b1;
        #1;
        check_output("ar_count",  32'(q_count),     32'd0);
        check_output("ar_pc",     32'(imem_addr),   32'd0);
        check_output("ar_instr",  32'(instr_out),   32'd0);
        check_output("ar_valid",  32'(issue_valid), 32'd0);
        check_output("ar_halted", 32'(halted),      32'd0);
        check_output("ar_done",   32'(done),        32'd0);
        model_reset();
        #1;
        CLR = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step();
        check_output("ar_restart_pc", 32'(imem_addr), 32'd1);
        for (int i = 0; i < 3; i++) step();

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[2:0] = 3'($urandom_range(0, 6));
            rom[i] = w;
        end
        rom[150] = 16'h0007;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            apply_stimulus($urandom_range(0, 9) != 0,
                           $urandom_range(0, 2) == 0,
                           $urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
